test_signals_receiver: RTL

//   Receiving end of the test-pattern path. Takes an external trigger and 16 test signals,

---
 rtl/test_signals_receiver.sv | 109 ++++++++++
 1 files changed

// File: rtl/test_signals_receiver.sv
// Loopback test-pattern receiver: synchronises trigger + 16 channels, timestamps first rising edge per channel in a fixed window.
// Edge-to-capture latency 3 clk from pin; no backpressure; RX_EVENT_COUNTER_EN adds evt_count_o (completed-window count).
module test_signals_receiver #(
  parameter int N_CH          = 16,
  parameter int WINDOW_CYCLES = 256,
  parameter int TS_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    trigger_i,
  input  logic [N_CH-1:0]         signals_i,
  input  logic [$clog2(N_CH)-1:0] rd_ch_i,
  output logic [TS_WIDTH-1:0]     rd_time_o,
  output logic [N_CH-1:0]         hit_mask_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
`ifdef RX_EVENT_COUNTER_EN
  ,
  output logic [15:0]             evt_count_o
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [TS_WIDTH-1:0] CNT_LAST = TS_WIDTH'(WINDOW_CYCLES - 1);

  // Trigger rides in the top bit so it sees exactly the same pipeline as the channels.
  logic [N_CH:0] sync_q1;
  logic [N_CH:0] sync_q2;
  logic [N_CH:0] sync_q3;
  logic [N_CH:0] rise;
  logic          trig_rise;
  logic [N_CH-1:0] ch_rise;

  logic [1:0]          state;
  logic [TS_WIDTH-1:0] cnt;
  logic [TS_WIDTH-1:0] ts [N_CH];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      sync_q3 <= '0;
    end else begin
      sync_q1 <= {trigger_i, signals_i};
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign rise      = sync_q2 & ~sync_q3;
  assign trig_rise = rise[N_CH];
  assign ch_rise   = rise[N_CH-1:0];

  assign busy_o = (state == ST_CAPTURE);
  assign done_o = (state == ST_DONE);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hit_mask_o <= '0;
      overrun_o  <= 1'b0;
      for (int i = 0; i < N_CH; i++) ts[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (trig_rise) begin
            state      <= ST_CAPTURE;
            cnt        <= '0;
            hit_mask_o <= '0;
            for (int i = 0; i < N_CH; i++) ts[i] <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          // Only the first edge per channel counts; later ones are ignored.
          for (int i = 0; i < N_CH; i++) begin
            if (ch_rise[i] && !hit_mask_o[i]) begin
              hit_mask_o[i] <= 1'b1;
              ts[i]         <= cnt;
            end
          end
          if (trig_rise) overrun_o <= 1'b1;
          if (cnt == CNT_LAST) state <= ST_DONE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rd_time_o <= '0;
    else          rd_time_o <= ts[rd_ch_i];
  end

`ifdef RX_EVENT_COUNTER_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)    evt_count_o <= '0;
    else if (done_o) evt_count_o <= evt_count_o + 16'd1;
  end
`endif

endmodule
